serial_add_ctrl: RTL and testbench

- Bit-serial adder sequencer built around one single-bit full-adder cell (fa1). The cell is instantiated internally.
- Loads two WIDTH-bit operands and feeds the cell one bit pair per clock, LSB first, with a registered carry loop.
- Collects the sum bits, then reports sum, carry-out and signed overflow with a start/busy/done handshake.
- Sits between the ALU operand registers and the result bus. It is the area-minimal add path for the CPLD ALU.

---
 rtl/serial_add_ctrl.sv | 129 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell, LSB first, with a registered carry loop and a start/busy/done handshake.
// Optional subtract mode is enabled with `define SERIAL_ADD_SUB_EN (adds the sub input).

module fa1 (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

// Handshake: start is accepted only on a clock edge where the state is IDLE; busy is high from the
// cycle after acceptance through the done cycle; done is a one-cycle pulse and sum/co/ovf hold until
// the next accepted start completes.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf,
    output logic [1:0]       state_dbg
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr, sum_sr, sum_nxt;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             last_bit;
    logic             cell_b, cell_s, cell_co;
`ifdef SERIAL_ADD_SUB_EN
    logic             sub_r;
`endif

`ifdef SERIAL_ADD_SUB_EN
    assign cell_b = b_sr[0] ^ sub_r;
`else
    assign cell_b = b_sr[0];
`endif

    fa1 u_fa1 (
        .a  (a_sr[0]),
        .b  (cell_b),
        .ci (carry),
        .s  (cell_s),
        .co (cell_co)
    );

    assign last_bit  = (cnt == CW'(WIDTH - 1));
    assign sum_nxt   = WIDTH'({cell_s, sum_sr} >> 1);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            sum_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            co     <= 1'b0;
            ovf    <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
            sub_r  <= 1'b0;
`endif
        end else begin
            if (state == IDLE && start) begin
                a_sr  <= a;
                b_sr  <= b;
                cnt   <= '0;
`ifdef SERIAL_ADD_SUB_EN
                sub_r <= sub;
                carry <= sub ? 1'b1 : ci;
`else
                carry <= ci;
`endif
            end else if (state == SHIFT) begin
                sum_sr <= sum_nxt;
                a_sr   <= a_sr >> 1;
                b_sr   <= b_sr >> 1;
                carry  <= cell_co;
                cnt    <= cnt + 1'b1;
                if (last_bit) begin
                    // During the MSB cycle the carry register still holds the carry into the MSB.
                    sum <= sum_nxt;
                    co  <= cell_co;
                    ovf <= carry ^ cell_co;
                end
            end
        end
    end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl (WIDTH=8): vector table plus hand-written handshake/reset sequences.
// Subtract vectors are added when SERIAL_ADD_SUB_EN is defined.

module tb_serial_add_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         ci = 1'b0;
    logic         sub = 1'b0;
    logic         busy, done, co, ovf;
    logic [W-1:0] sum;
    logic [1:0]   state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W+1:0] exp_q[$];

    typedef struct {
        logic [W-1:0] va, vb;
        logic         vci, vsub;
        logic [W-1:0] e_sum;
        logic         e_co, e_ovf;
    } vec_t;
    vec_t vecs[$];

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .ci        (ci),
`ifdef SERIAL_ADD_SUB_EN
        .sub       (sub),
`endif
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .co        (co),
        .ovf       (ovf),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Presents operands with start for exactly one edge; returns at the negedge after that edge.
    task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tci, input logic tsub);
        @(negedge clk);
        a = ta; b = tb_v; ci = tci; sub = tsub; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = $urandom_range(255, 0); b = $urandom_range(255, 0); ci = $urandom_range(1, 0);
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run_op(input string name, input vec_t v);
        int           cyc;
        logic [W+1:0] e;
        exp_q.push_back({v.e_co, v.e_ovf, v.e_sum});
        launch(v.va, v.vb, v.vci, v.vsub);
        check({name, " busy"}, 32'(busy), 32'd1);
        wait_done(cyc);
        check({name, " latency"}, 32'(cyc), 32'(W));
        e = exp_q.pop_front();
        check({name, " sum"}, 32'(sum), 32'(e[W-1:0]));
        check({name, " co"},  32'(co),  32'(e[W+1]));
        check({name, " ovf"}, 32'(ovf), 32'(e[W]));
        @(negedge clk);
        check({name, " done_pulse"}, 32'({done, busy}), 32'd0);
    endtask

    initial begin
        int cyc, ndone, t1, t2;

        vecs.push_back('{8'h3C, 8'h0F, 1'b0, 1'b0, 8'h4B, 1'b0, 1'b0});
        vecs.push_back('{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0});
        vecs.push_back('{8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1});
        vecs.push_back('{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1});
        vecs.push_back('{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0});
        vecs.push_back('{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0});
        vecs.push_back('{8'h40, 8'h40, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1});
        vecs.push_back('{8'hA5, 8'h5A, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0});
`ifdef SERIAL_ADD_SUB_EN
        vecs.push_back('{8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0});
        vecs.push_back('{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1});
        vecs.push_back('{8'h07, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0});
        vecs.push_back('{8'h3C, 8'h0F, 1'b0, 1'b0, 8'h4B, 1'b0, 1'b0});
`endif

        // Clock/reset
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset outs", 32'({busy, done, co, ovf, sum}), 32'd0);
        check("reset state", 32'(state_dbg), 32'd0);

        for (int i = 0; i < vecs.size(); i++)
            run_op($sformatf("vec%0d", i), vecs[i]);

        // Second start during SHIFT is ignored; exactly one done with the first result.
        launch(8'h10, 8'h20, 1'b0, 1'b0);
        check("shift state", 32'(state_dbg), 32'd1);
        repeat (2) @(negedge clk);
        a = 8'hAA; b = 8'h55; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 2 * W + 4; i++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                check("ignored sum", 32'(sum), 32'h30);
                check("ignored co/ovf", 32'({co, ovf}), 32'd0);
            end
        end
        check("ignored ndone", 32'(ndone), 32'd1);

        // Reset mid-operation discards the result and clears outputs.
        launch(8'h12, 8'h34, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check("sum holds", 32'(sum), 32'h30);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst outs", 32'({busy, done, co, ovf, sum}), 32'd0);
        ndone = 0;
        for (int i = 0; i < W + 4; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("midrst no done", 32'(ndone), 32'd0);
        run_op("after rst", '{8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0});

        // start held high: one op per W+2 cycles.
        @(negedge clk);
        a = 8'h01; b = 8'h01; ci = 1'b0; start = 1'b1;
        t1 = -1; t2 = -1;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (done) begin
                if (t1 < 0) begin
                    t1 = n;
                    check("held1 res", 32'({co, ovf, sum}), 32'h002);
                    a = 8'h80; b = 8'h80;
                end else if (t2 < 0) begin
                    t2 = n;
                    check("held2 res", 32'({co, ovf, sum}), 32'h200 | 32'h100);
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        check("held t1", 32'(t1), 32'd9);
        check("held t2", 32'(t2), 32'd19);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
